// File: rtl/mem_test_engine.sv
// Looping write-then-readback memory tester on a req/ack word port with pass/fail counters.
// Latency: one access per cycle at zero-wait ack; one DONE bubble between passes.
// Backpressure: request and its addr/we/wdata hold until mem_ack. MEMTEST_ERR_CAPTURE_EN enables first-error capture.
module mem_test_engine #(
    parameter int              ADDR_W    = 24,
    parameter int              DATA_W    = 16,
    parameter longint unsigned BASE_ADDR = 0,
    parameter longint unsigned WORDS     = 64'd1 << ADDR_W,
    parameter logic [31:0]     LFSR_SEED = 32'hACE12468
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [1:0]        mode,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        state,
    output logic [31:0]       passcount,
    output logic [31:0]       failcount,
    output logic              err_seen,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_got
);
    localparam int IDX_W = $clog2(WORDS) + 1;
    localparam int POS_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       lfsr_q, snap_q, lfsr_next;
    logic [POS_W-1:0]  pass_pos_q, walk_pos_q, pass_pos_next, walk_pos_next;
    logic [ADDR_W-1:0] addr_raw;
    logic [DATA_W-1:0] pat;
    logic              req, ack_ok, last, mismatch;

    assign lfsr_next     = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    assign walk_pos_next = (walk_pos_q == POS_LAST) ? '0 : walk_pos_q + 1'b1;
    assign pass_pos_next = (pass_pos_q == POS_LAST) ? '0 : pass_pos_q + 1'b1;
    assign addr_raw      = BASE + ADDR_W'(idx_q);
    assign last          = (idx_q == LAST_IDX);

    // walk_pos tracks (idx + pass) mod DATA_W incrementally, avoiding a divider
    always_comb begin
        pat = lfsr_q[DATA_W-1:0];
        case (mode_q)
            2'd1:    pat = DATA_W'(1) << walk_pos_q;
            2'd2:    pat = DATA_W'(addr_raw) ^ {DATA_W{passcount[0]}};
            default: pat = lfsr_q[DATA_W-1:0];
        endcase
    end

    // Request qualifiers come straight from the state flop so reset drops them at once
    assign req       = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign mem_req   = req;
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_addr  = req ? addr_raw : '0;
    assign mem_wdata = mem_we ? pat : '0;
    assign ack_ok    = req && mem_ack;
    assign mismatch  = ack_ok && !mem_we && (mem_rdata != pat);
    assign busy      = (state_q != ST_IDLE);
    assign state     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_WRITE;
            ST_WRITE: if (mem_ack && last) state_d = ST_READ;
            ST_READ:  if (mem_ack && last) state_d = ST_DONE;
            default:  state_d = run ? ST_WRITE : ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= '0;
            idx_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            snap_q     <= LFSR_SEED;
            pass_pos_q <= '0;
            walk_pos_q <= '0;
            passcount  <= '0;
            failcount  <= '0;
        end else begin
            if ((state_q == ST_IDLE || state_q == ST_DONE) && run) mode_q <= mode;
            if (ack_ok) begin
                if (last && mem_we) begin
                    // read phase replays the same sequence from the pass-start seed
                    idx_q      <= '0;
                    lfsr_q     <= snap_q;
                    walk_pos_q <= pass_pos_q;
                end else begin
                    idx_q      <= last ? '0 : idx_q + 1'b1;
                    lfsr_q     <= lfsr_next;
                    walk_pos_q <= walk_pos_next;
                end
            end
            if (state_q == ST_DONE) begin
                passcount  <= passcount + 32'd1;
                snap_q     <= lfsr_q;
                pass_pos_q <= pass_pos_next;
                walk_pos_q <= pass_pos_next;
            end
            if (mismatch && (failcount != 32'hFFFF_FFFF)) failcount <= failcount + 32'd1;
        end
    end

`ifdef MEMTEST_ERR_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_seen <= 1'b0;
            err_addr <= '0;
            err_exp  <= '0;
            err_got  <= '0;
        end else if (mismatch && !err_seen) begin
            err_seen <= 1'b1;
            err_addr <= addr_raw;
            err_exp  <= pat;
            err_got  <= mem_rdata;
        end
    end
`else
    assign err_seen = 1'b0;
    assign err_addr = '0;
    assign err_exp  = '0;
    assign err_got  = '0;
`endif
endmodule

// File: tb/tb_mem_test_engine.sv
// Bench for mem_test_engine: behavioural memory with fault injection, access-level reference model,
// and directed scenarios with hand-computed end results.
module tb_mem_test_engine;
    localparam int AW = 24, DW = 16, BASE = 8, NW = 16;
    localparam logic [31:0] SEED = 32'hACE12468;
`ifdef MEMTEST_ERR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, run = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          mem_req, mem_we, mem_ack = 1'b0;
    logic [AW-1:0] mem_addr, err_addr;
    logic [DW-1:0] mem_wdata, mem_rdata = '0, err_exp, err_got;
    logic          busy, err_seen;
    logic [1:0]    state;
    logic [31:0]   passcount, failcount;

    int n_vec = 0, n_miss = 0;

    mem_test_engine #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .WORDS(NW), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mode(mode),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .state(state), .passcount(passcount), .failcount(failcount),
        .err_seen(err_seen), .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [15:0] pattern(input logic [1:0] md, input int pass, input int idx,
                                            input logic [31:0] seed);
        logic [31:0] s;
        s = seed;
        case (md)
            2'd1:    return 16'h0001 << ((idx + pass) % DW);
            2'd2:    return (pass % 2 == 1) ? ~16'(BASE + idx) : 16'(BASE + idx);
            default: begin
                for (int i = 0; i < idx; i++) s = lfsr_step(s);
                return s[15:0];
            end
        endcase
    endfunction

    // Memory with optional stuck-at-0 on bit 3 of addr 11 and addr 20 aliased onto addr 12
    logic [15:0] mem [0:63];
    bit          stuck_en = 0, alias_en = 0, lat_rand = 0;
    bit          pend = 0;
    int          wait_left = 0;
    logic [5:0]  phys;
    logic [AW-1:0] cap_addr;
    logic        cap_we;
    logic [DW-1:0] cap_wdata;

    initial for (int i = 0; i < 64; i++) mem[i] = '0;

    always begin
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        if (!rst_n || !mem_req) begin
            pend = 0;
        end else begin
            if (!pend) begin
                pend      = 1;
                cap_addr  = mem_addr;
                cap_we    = mem_we;
                cap_wdata = mem_wdata;
                wait_left = lat_rand ? int'($urandom_range(0, 7)) : 0;
            end else begin
                chk("hold_addr", 32'(mem_addr), 32'(cap_addr));
                chk("hold_we", 32'(mem_we), 32'(cap_we));
                chk("hold_wdata", 32'(mem_wdata), 32'(cap_wdata));
            end
            if (wait_left == 0) begin
                mem_ack = 1'b1;
                pend    = 0;
                phys    = (alias_en && mem_addr == 24'd20) ? 6'd12 : mem_addr[5:0];
                if (mem_we) mem[phys] = mem_wdata;
                else begin
                    mem_rdata = mem[phys];
                    if (stuck_en && mem_addr == 24'd11) mem_rdata[3] = 1'b0;
                end
            end else begin
                wait_left--;
            end
        end
    end

    // Reference model: expected access k of a pass, plus counters derived from observed read data
    int          k = 0, m_pass = 0, c_idx;
    bit          c_wr, m_err = 0, gap_chk = 0, preload_req = 0, preload_taken = 0;
    logic [31:0] m_seed = SEED, m_fail = 0;
    logic [15:0] c_exp, m_eexp = 0, m_egot = 0;
    logic [23:0] m_eaddr = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            k = 0; m_pass = 0; m_seed = SEED; m_fail = 0; m_err = 0;
            m_eaddr = 0; m_eexp = 0; m_egot = 0; gap_chk = 0; preload_taken = 0;
        end else begin
            if (preload_req && !preload_taken) begin
                m_fail = 32'hFFFF_FFFE;
                preload_taken = 1;
            end
            if (gap_chk) chk("no_gap_req", 32'(mem_req), 32'd1);
            gap_chk = 0;
            if (mem_req && mem_ack) begin
                c_idx = k % NW;
                c_wr  = (k < NW);
                c_exp = pattern(mode, m_pass, c_idx, m_seed);
                chk("passcount", passcount, 32'(m_pass));
                chk("failcount", failcount, m_fail);
                chk("err_seen", 32'(err_seen), 32'(CAP & m_err));
                chk("err_addr", 32'(err_addr), CAP ? 32'(m_eaddr) : 32'd0);
                chk("err_exp", 32'(err_exp), CAP ? 32'(m_eexp) : 32'd0);
                chk("err_got", 32'(err_got), CAP ? 32'(m_egot) : 32'd0);
                chk("acc_we", 32'(mem_we), 32'(c_wr));
                chk("acc_addr", 32'(mem_addr), 32'(BASE + c_idx));
                if (c_wr) begin
                    chk("acc_wdata", 32'(mem_wdata), 32'(c_exp));
                end else if (mem_rdata !== c_exp) begin
                    if (m_fail != 32'hFFFF_FFFF) m_fail = m_fail + 1;
                    if (!m_err) begin
                        m_err = 1; m_eaddr = 24'(BASE + c_idx); m_eexp = c_exp; m_egot = mem_rdata;
                    end
                end
                k++;
                if (k == 2 * NW) begin
                    k = 0;
                    m_pass++;
                    for (int i = 0; i < NW; i++) m_seed = lfsr_step(m_seed);
                end else begin
                    gap_chk = 1;
                end
            end
        end
    end

    task automatic apply_reset();
        run = 0;
        preload_req = 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 20000) begin @(negedge clk); t++; end
        if (t >= 20000) chk("timeout_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_passes(input logic [1:0] md, input int n);
        int t = 0;
        int target;
        target = int'(passcount) + n - 1;
        mode = md;
        run  = 1;
        @(posedge clk);
        #1;
        while (int'(passcount) != target && t < 20000) begin @(negedge clk); t++; end
        if (t >= 20000) chk("timeout_pass", passcount, 32'(target));
        run = 0;
        wait_idle();
    endtask

    task automatic wait_acks(input bit want_we, input int n);
        int cnt = 0, t = 0;
        while (cnt < n && t < 5000) begin
            @(negedge clk);
            t++;
            if (mem_req && mem_ack && (mem_we == want_we)) cnt++;
        end
        if (cnt < n) chk("timeout_acks", 32'(cnt), 32'(n));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_pass"}, passcount, 0);
        chk({tag, "_fail"}, failcount, 0);
        chk({tag, "_eseen"}, 32'(err_seen), 0);
        chk({tag, "_eaddr"}, 32'(err_addr), 0);
        chk({tag, "_eexp"}, 32'(err_exp), 0);
        chk({tag, "_egot"}, 32'(err_got), 0);
    endtask

    task automatic chk_err(input string tag, input int fails, input int a, input int e, input int g);
        chk({tag, "_failcount"}, failcount, 32'(fails));
        chk({tag, "_err_seen"}, 32'(err_seen), CAP ? 32'd1 : 32'd0);
        chk({tag, "_err_addr"}, 32'(err_addr), CAP ? 32'(a) : 32'd0);
        chk({tag, "_err_exp"}, 32'(err_exp), CAP ? 32'(e) : 32'd0);
        chk({tag, "_err_got"}, 32'(err_got), CAP ? 32'(g) : 32'd0);
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        apply_reset();
        chk_all_zero("reset");

        // LFSR mode, perfect memory, 3 passes
        mode = 2'd0;
        run  = 1;
        @(posedge clk);
        @(negedge clk);
        chk("first_we", 32'(mem_we), 32'd1);
        chk("first_addr", 32'(mem_addr), 32'd8);
        chk("first_wdata", 32'(mem_wdata), 32'h2468);
        @(negedge clk);
        chk("second_addr", 32'(mem_addr), 32'd9);
        chk("second_wdata", 32'(mem_wdata), 32'h48D0);
        wait_pass_loop: begin
            int t = 0;
            while (passcount != 32'd2 && t < 20000) begin @(negedge clk); t++; end
            if (t >= 20000) chk("timeout_pass", passcount, 32'd2);
        end
        run = 0;
        wait_idle();
        chk("t1_passcount", passcount, 32'd3);
        chk("t1_failcount", failcount, 32'd0);
        chk("t1_err_seen", 32'(err_seen), 32'd0);
        chk("t1_state", 32'(state), 32'd0);

        // Walking-one with stuck bit 3 at addr 11: fails on passes 0 and 16
        apply_reset();
        stuck_en = 1;
        run_passes(2'd1, 17);
        chk("t2_passcount", passcount, 32'd17);
        chk_err("t2", 2, 11, 16'h0008, 16'h0000);
        stuck_en = 0;

        // Address-as-data with addr 20 aliased onto 12
        apply_reset();
        alias_en = 1;
        run_passes(2'd2, 1);
        chk_err("t3", 1, 12, 16'h000C, 16'h0014);

        // Same fault under random ack latency
        apply_reset();
        lat_rand = 1;
        run_passes(2'd2, 2);
        chk("t4_passcount", passcount, 32'd2);
        chk_err("t4", 2, 12, 16'h000C, 16'h0014);
        lat_rand = 0;
        alias_en = 0;

        // run dropped at 5th read ack, then reset mid-write of a later run
        apply_reset();
        mode = 2'd0;
        run  = 1;
        wait_acks(1'b0, 5);
        run = 0;
        wait_idle();
        chk("t5_passcount", passcount, 32'd1);
        chk("t5_state", 32'(state), 32'd0);
        chk("t5_req", 32'(mem_req), 32'd0);
        run = 1;
        wait_acks(1'b1, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("t5_rst");
        run = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Saturation from a preloaded failcount
        apply_reset();
        @(negedge clk);
        force dut.failcount = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.failcount;
        #1;
        chk("t6_preload", failcount, 32'hFFFF_FFFE);
        preload_req = 1;
        alias_en = 1;
        run_passes(2'd2, 3);
        chk("t6_failcount", failcount, 32'hFFFF_FFFF);
        chk("t6_passcount", passcount, 32'd3);
        alias_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
